// File: rtl/cac_uart_transmitter_if.sv
// rtl/cac_uart_transmitter_if.sv - byte valid/ready handshake into the CAC UART transmitter
interface cac_uart_transmitter_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/cac_uart_transmitter.sv
// rtl/cac_uart_transmitter.sv - CAC link UART transmitter: byte FIFO feeding an MSB-first start/data/stop serialiser
module cac_uart_transmitter #(
   parameter int CLOCK_FREQUENCY = 100_000_000,
   parameter int BAUDRATE        = 115200,
   parameter int FIFO_DEPTH      = 8,
   parameter int STOP_BITS       = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   cac_uart_transmitter_if.slave       host,
   output logic                        uart_tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
   localparam int CPB         = CLOCK_FREQUENCY / BAUDRATE;
   localparam int STOP_CYCLES = STOP_BITS * CPB;
   localparam int CNT_W       = $clog2(STOP_CYCLES + 1);
   localparam int PW          = $clog2(FIFO_DEPTH);
   localparam int CW          = PW + 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
   logic [2:0]       bit_cnt, bit_cnt_nx;
   logic [7:0]       shift, shift_nx;
   logic             uart_tx_nx;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [7:0]       mem [FIFO_DEPTH];
   logic             push, pop;

   // Ready is held low through reset so no byte can slip in while pointers clear.
   assign host.tx_ready = rst && (fifo_count < CW'(FIFO_DEPTH));
   assign push          = host.tx_valid && host.tx_ready;
   assign busy          = (state != IDLE) || (fifo_count != '0);

   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_cnt + CNT_W'(1);
      bit_cnt_nx  = bit_cnt;
      shift_nx    = shift;
      uart_tx_nx  = uart_tx;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            uart_tx_nx  = 1'b1;
            baud_cnt_nx = '0;
            if (fifo_count != '0) begin
               pop        = 1'b1;
               shift_nx   = mem[rd_ptr];
               uart_tx_nx = 1'b0;
               state_nx   = START;
            end
         end
         START: begin
            if (baud_cnt == BIT_LAST) begin
               baud_cnt_nx = '0;
               bit_cnt_nx  = '0;
               uart_tx_nx  = shift[7];
               state_nx    = DATA;
            end
         end
         DATA: begin
            if (baud_cnt == BIT_LAST) begin
               baud_cnt_nx = '0;
               if (bit_cnt == 3'd7) begin
                  uart_tx_nx = 1'b1;
                  state_nx   = STOP;
               end else begin
                  shift_nx   = {shift[6:0], 1'b0};
                  uart_tx_nx = shift[6];
                  bit_cnt_nx = bit_cnt + 3'd1;
               end
            end
         end
         STOP: begin
            // A queued byte starts its start bit straight out of the stop bit, no idle gap.
            if (baud_cnt == STOP_LAST) begin
               baud_cnt_nx = '0;
               if (fifo_count != '0) begin
                  pop        = 1'b1;
                  shift_nx   = mem[rd_ptr];
                  uart_tx_nx = 1'b0;
                  state_nx   = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx   = IDLE;
            uart_tx_nx = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         uart_tx    <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state      <= state_nx;
         baud_cnt   <= baud_cnt_nx;
         bit_cnt    <= bit_cnt_nx;
         shift      <= shift_nx;
         uart_tx    <= uart_tx_nx;
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= host.tx_data;
      end
   end
endmodule

// File: doc/cac_uart_transmitter.md
Name: cac_uart_transmitter

Overview:
UART transmit side of the communication-and-control (CAC) link. It is the counterpart of the existing cac_uart_rx receive path and drives the cac_uart_tx pin of the top level.
Bytes are accepted through a valid/ready handshake into a small FIFO, then serialised with 8N1-style framing: one start bit, 8 data bits MSB-first, then the stop bit(s).
Bit order matches what the CAC receiver expects: start, bit7 … bit0, stop.

Parameters:
CLOCK_FREQUENCY, 100_000_000, clk frequency in Hz (top level passes MASTER_CLOCK_FREQUENCY).
BAUDRATE, 115200, line rate in bit/s (top level passes CAC_UART_BAUDRATE).
FIFO_DEPTH, 8, byte entries in the transmit FIFO; power of two, ≥2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0)
tx_data  input  8  byte to send
tx_valid  input  1  tx_data is valid
tx_ready  output  1  FIFO can accept a byte this cycle
uart_tx  output  1  serial line, idles high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO

Behaviour:
- Derived constant CPB = CLOCK_FREQUENCY/BAUDRATE (integer division). CPB ≥ 4 is required.
- Reset, sampled on the clk edge while rst == 0:
  - uart_tx = 1, busy = 0, fifo_count = 0, state = IDLE.
  - Baud counter, bit counter and FIFO pointers are cleared.
  - tx_ready stays 0 while reset is held.
  - A reset mid-frame aborts the frame; uart_tx is high from that edge on.
- Handshake:
  - tx_ready = (fifo_count < FIFO_DEPTH), combinational.
  - A byte is written when tx_valid && tx_ready at a clk edge.
  - When full, tx_ready is 0 even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_count unchanged.
- FSM states are IDLE, START, DATA, STOP. uart_tx is a registered output.
- IDLE:
  - uart_tx = 1.
  - If fifo_count > 0 at an edge: pop the FIFO head into the shift register, uart_tx <= 0, go to START, baud counter cleared.
  - A byte written at edge N starts the start bit at edge N+1.
- START: after CPB cycles, uart_tx <= shift[7], go to DATA, bit counter = 0.
- DATA:
  - Every CPB cycles, shift left.
  - After the 8th bit has been held for CPB cycles, uart_tx <= 1 and go to STOP.
- STOP:
  - The line is held high for STOP_BITS*CPB cycles.
  - At the end, if the FIFO is non-empty: pop immediately, uart_tx <= 0, go to START (no idle gap).
  - Otherwise go to IDLE.
- Timing:
  - Every bit lasts exactly CPB cycles.
  - Frame length is (9+STOP_BITS)*CPB cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- FIFO: pointers wrap modulo FIFO_DEPTH. No overflow is possible (handshake-gated) and no underflow is possible (pop only when non-empty).

Test Plan:
All tests use CLOCK_FREQUENCY=1_000_000, BAUDRATE=100_000, so CPB=10.
- Reset values: hold rst=0 for 5 cycles → uart_tx=1, busy=0, fifo_count=0, tx_ready=0. Release rst → tx_ready=1, uart_tx stays 1.
- Single byte 0x11 pushed at edge N:
  - uart_tx=0 over cycles N+1..N+10.
  - Then the data bits 0,0,0,1,0,0,0,1 follow, 10 cycles each.
  - Then the line is 1 from N+91 on; busy drops at N+101.
- Back-to-back: push 0x11, 0x01, 0x11, 0x11, 0x30 in consecutive cycles → 5 contiguous 100-cycle frames with no idle gap. Decoded MSB-first they read 0x11, 0x01, 0x11, 0x11, 0x30.
- FIFO full (FIFO_DEPTH=8): hold tx_valid=1 for 12 cycles from idle →
  - exactly 9 bytes accepted (1 popped, 8 held);
  - tx_ready=0 after the 9th accept, fifo_count=8;
  - tx_ready returns to 1 on the cycle after the next pop (frame end, cycle 100).
- Reset mid-frame: assert rst=0 during data bit 3 of 0xA5 → uart_tx=1 at that edge and FIFO emptied. After release, no residual frame is emitted.
- STOP_BITS=2: send 0x55 then 0xAA → stop interval is 20 cycles and frame period is 110 cycles.
